// File: rtl/led_blink_arbiter_if.sv
// rtl/led_blink_arbiter_if.sv - requester/LED bundle shared by led_blink_arbiter and its clients
interface led_blink_arbiter_if #(
  parameter int NREQ = 4
);
  logic [NREQ-1:0]   req;
  logic [4*NREQ-1:0] count;
  logic [NREQ-1:0]   grant;
  logic              done;
  logic              led;

  modport master (output req, output count, input grant, input done, input led);
  modport slave  (input req, input count, output grant, output done, output led);
endinterface

// File: rtl/led_blink_arbiter.sv
// rtl/led_blink_arbiter.sv - arbitrates one status LED between NREQ blink-code requesters
// Optional LED_BLINK_ARB_FIXED_PRIO_EN: fixed lowest-index priority instead of round-robin.
module led_blink_arbiter #(
  parameter int NREQ      = 4,
  parameter int PRESCALE  = 2500,
  parameter int GAP_TICKS = 4
) (
  input  logic               clk,
  input  logic               rst,
  led_blink_arbiter_if.slave bus
);
  localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int TW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int GW   = $clog2(GAP_TICKS + 1);

  typedef enum logic [1:0] {S_IDLE, S_ON, S_OFF, S_GAP} state_e;

  state_e          state_q, state_d;
  logic [TW-1:0]   tick_cnt_q, tick_cnt_d;
  logic [3:0]      rem_q, rem_d;
  logic [GW-1:0]   gap_q, gap_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic            done_q, done_d;
  logic            led_q, led_d;

  logic            tick;
  logic            found;
  logic [IDXW-1:0] sel;
  logic [3:0]      sel_count;

`ifndef LED_BLINK_ARB_FIXED_PRIO_EN
  logic [IDXW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDXW:0]   cand;
`endif

  assign tick      = (state_q != S_IDLE) && (tick_cnt_q == TW'(PRESCALE - 1));
  assign sel_count = bus.count[{sel, 2'b00} +: 4];

  // First requesting index, scanning upward from the RR pointer with wrap.
  always_comb begin : arbitrate
    found = 1'b0;
    sel   = '0;
`ifdef LED_BLINK_ARB_FIXED_PRIO_EN
    for (int i = 0; i < NREQ; i++) begin
      if (!found && bus.req[i]) begin
        found = 1'b1;
        sel   = IDXW'(i);
      end
    end
`else
    cand = '0;
    for (int i = 0; i < NREQ; i++) begin
      cand = {1'b0, rr_ptr_q} + (IDXW+1)'(i);
      if (cand >= (IDXW+1)'(NREQ)) begin
        cand = cand - (IDXW+1)'(NREQ);
      end
      if (!found && bus.req[cand[IDXW-1:0]]) begin
        found = 1'b1;
        sel   = cand[IDXW-1:0];
      end
    end
`endif
  end

  always_comb begin : next_state
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    rem_d      = rem_q;
    gap_d      = gap_q;
`ifndef LED_BLINK_ARB_FIXED_PRIO_EN
    rr_ptr_d   = rr_ptr_q;
`endif
    if (state_q != S_IDLE) begin
      tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
    end
    case (state_q)
      S_IDLE: begin
        if (found) begin
          state_d    = S_ON;
          tick_cnt_d = '0;
          rem_d      = (sel_count == 4'd0) ? 4'd1 : sel_count;
`ifndef LED_BLINK_ARB_FIXED_PRIO_EN
          rr_ptr_d   = (sel == IDXW'(NREQ - 1)) ? '0 : sel + 1'b1;
`endif
        end
      end
      S_ON: begin
        if (tick) begin
          state_d = S_OFF;
          rem_d   = rem_q - 1'b1;
        end
      end
      S_OFF: begin
        if (tick) begin
          if (rem_q != 4'd0) begin
            state_d = S_ON;
          end else begin
            state_d = S_GAP;
            gap_d   = GW'(GAP_TICKS - 1);
          end
        end
      end
      S_GAP: begin
        if (tick) begin
          if (gap_q == '0) begin
            state_d = S_IDLE;
          end else begin
            gap_d = gap_q - 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are computed one edge ahead so led/grant/done leave flops directly.
  always_comb begin : outputs
    led_d   = led_q;
    grant_d = grant_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          grant_d = NREQ'(1) << sel;
          led_d   = 1'b1;
        end
      end
      S_ON: begin
        if (tick) begin
          led_d = 1'b0;
        end
      end
      S_OFF: begin
        if (tick && (rem_q != 4'd0)) begin
          led_d = 1'b1;
        end
      end
      S_GAP: begin
        if (tick && (gap_q == '0)) begin
          grant_d = '0;
          done_d  = 1'b1;
        end
      end
      default: begin
        led_d   = 1'b0;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      tick_cnt_q <= '0;
      rem_q      <= '0;
      gap_q      <= '0;
      grant_q    <= '0;
      done_q     <= 1'b0;
      led_q      <= 1'b0;
`ifndef LED_BLINK_ARB_FIXED_PRIO_EN
      rr_ptr_q   <= '0;
`endif
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      rem_q      <= rem_d;
      gap_q      <= gap_d;
      grant_q    <= grant_d;
      done_q     <= done_d;
      led_q      <= led_d;
`ifndef LED_BLINK_ARB_FIXED_PRIO_EN
      rr_ptr_q   <= rr_ptr_d;
`endif
    end
  end

  assign bus.grant = grant_q;
  assign bus.done  = done_q;
  assign bus.led   = led_q;
endmodule

// File: tb/tb_led_blink_arbiter.sv
// tb/tb_led_blink_arbiter.sv - self-checking bench for led_blink_arbiter against a sequence-level model
module tb_led_blink_arbiter;
  localparam int NREQ      = 4;
  localparam int PRESCALE  = 4;
  localparam int GAP_TICKS = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;

  led_blink_arbiter_if #(.NREQ(NREQ)) bus ();

  led_blink_arbiter #(
    .NREQ(NREQ), .PRESCALE(PRESCALE), .GAP_TICKS(GAP_TICKS)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  // Model: a sequence is just an owner, a blink count and a position in cycles.
  logic m_busy;
  logic m_done;
  int   m_pos;
  int   m_n;
  int   m_owner;
  int   m_ptr;

  function automatic int pick(logic [NREQ-1:0] r, int ptr);
    int j;
    for (int i = 0; i < NREQ; i++) begin
`ifdef LED_BLINK_ARB_FIXED_PRIO_EN
      j = i;
`else
      j = (ptr + i) % NREQ;
`endif
      if (r[j]) return j;
    end
    return 0;
  endfunction

  function automatic int req_count(logic [4*NREQ-1:0] c, int k);
    int v;
    v = int'(c[4*k +: 4]);
    return (v == 0) ? 1 : v;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy  <= 1'b0;
      m_done  <= 1'b0;
      m_pos   <= 0;
      m_n     <= 0;
      m_owner <= 0;
      m_ptr   <= 0;
    end else if (!m_busy) begin
      m_done <= 1'b0;
      if (bus.req != '0) begin
        m_busy  <= 1'b1;
        m_pos   <= 0;
        m_owner <= pick(bus.req, m_ptr);
        m_n     <= req_count(bus.count, pick(bus.req, m_ptr));
        m_ptr   <= (pick(bus.req, m_ptr) + 1) % NREQ;
      end
    end else if (m_pos + 1 == (2 * m_n + GAP_TICKS) * PRESCALE) begin
      m_busy <= 1'b0;
      m_done <= 1'b1;
      m_pos  <= 0;
    end else begin
      m_pos <= m_pos + 1;
    end
  end

  function automatic int exp_grant();
    return m_busy ? (1 << m_owner) : 0;
  endfunction

  function automatic int exp_led();
    return (m_busy && (m_pos < 2 * m_n * PRESCALE) && (((m_pos / PRESCALE) % 2) == 0)) ? 1 : 0;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Every wait advances through here, so the model is compared on each cycle.
  task automatic step();
    @(negedge clk);
    cyc++;
    if (!rst) begin
      check("model_grant", int'(bus.grant), exp_grant());
      check("model_led", int'(bus.led), exp_led());
      check("model_done", int'(bus.done), int'(m_done));
    end
  endtask

  task automatic wait_grant();
    for (int n = 0; n < 300 && bus.grant == '0; n++) step();
    check("grant_timeout", int'(bus.grant != '0), 1);
  endtask

  task automatic run_seq(input int drop_at, input logic [NREQ-1:0] nreq,
                         input logic [4*NREQ-1:0] ncnt,
                         output int c, output int hi, output int rises);
    logic prev;
    c = 0; hi = 0; rises = 0; prev = 1'b0;
    for (int n = 0; n < 1000; n++) begin
      if (c == drop_at) begin
        bus.req   = nreq;
        bus.count = ncnt;
      end
      if (bus.done) break;
      hi += int'(bus.led);
      if (bus.led && !prev) rises++;
      prev = bus.led;
      step();
      c++;
    end
    check("done_timeout", int'(bus.done), 1);
  endtask

  int c, hi, rises;
  int exp_g[5] = '{1, 2, 4, 8, 1};

  initial begin
    bus.req   = '0;
    bus.count = '0;
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    step();
    check("reset_grant", int'(bus.grant), 0);
    check("reset_led", int'(bus.led), 0);
    check("reset_done", int'(bus.done), 0);

    // Single request, three blinks, request held for one cycle only
    bus.req = 4'b0001; bus.count = 16'h0003;
    step();
    check("single_grant", int'(bus.grant), 1);
    run_seq(0, 4'b0000, 16'h0003, c, hi, rises);
    check("single_len", c, 32);
    check("single_led_hi", hi, 12);
    check("single_pulses", rises, 3);

    // Zero count behaves as one blink
    bus.req = 4'b0010; bus.count = 16'h0000;
    step();
    check("zero_grant", int'(bus.grant), 2);
    run_seq(0, 4'b0000, 16'h0000, c, hi, rises);
    check("zero_len", c, 16);
    check("zero_led_hi", hi, 4);
    check("zero_pulses", rises, 1);

    rst = 1'b1;
    step(); step();
    rst = 1'b0;

`ifdef LED_BLINK_ARB_FIXED_PRIO_EN
    bus.req = 4'b0101; bus.count = 16'h1111;
    for (int i = 0; i < 4; i++) begin
      wait_grant();
      check("fixed_grant", int'(bus.grant), 1);
      run_seq(-1, 4'b0101, 16'h1111, c, hi, rises);
    end
    bus.req = '0;
    step();
`else
    bus.req = 4'b1111; bus.count = 16'h1111;
    for (int i = 0; i < 5; i++) begin
      wait_grant();
      check("rr_grant", int'(bus.grant), exp_g[i]);
      run_seq(-1, 4'b1111, 16'h1111, c, hi, rises);
      check("rr_len", c, 16);
      if (i < 4) begin
        step();
        check("rr_idle_gap", int'(bus.grant != '0), 1);
      end else begin
        bus.req = '0;
        step();
      end
    end
`endif

    // Request drop and count change mid-ON must not disturb the sequence
    bus.req = 4'b0100; bus.count = 16'h0200;
    step();
    check("drop_grant", int'(bus.grant), 4);
    run_seq(2, 4'b0000, 16'h0500, c, hi, rises);
    check("drop_len", c, 24);
    check("drop_led_hi", hi, 8);
    check("drop_pulses", rises, 2);

    // Reset while in OFF
    bus.req = 4'b1111; bus.count = 16'h2222;
    wait_grant();
    repeat (5) step();
    check("pre_reset_led", int'(bus.led), 0);
    #2 rst = 1'b1;
    #1;
    check("async_rst_led", int'(bus.led), 0);
    check("async_rst_grant", int'(bus.grant), 0);
    check("async_rst_done", int'(bus.done), 0);
    step(); step();
    rst = 1'b0;
    step();
    check("post_reset_grant", int'(bus.grant), 1);

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        bus.req   = 4'($urandom);
        bus.count = 16'($urandom);
      end
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
